// File: rtl/alu_exec_if.sv
// alu_exec_if: request/response bundle between the issue stage, alu_exec_unit and writeback
interface alu_exec_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [3:0]      op_code;
  logic            busy;
  modport master (
    output in_valid, alu_op, funct3, funct7, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, op_code, busy
  );
  modport slave (
    input  in_valid, alu_op, funct3, funct7, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, op_code, busy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: ALU execute stage with valid/ready handshake; iterative shifter by default,
// single-cycle barrel shifter when FAST_SHIFT_EN is defined.
module alu_exec_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input logic       clk,
  input logic       rst,
  alu_exec_if.slave bus
);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3, OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7, OP_SLT = 4'd8, OP_SLTU = 4'd9;
`ifdef FAST_SHIFT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif
  state_t          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d, alu_res;
  logic            zero_q, zero_d;
  logic [3:0]      op_code_q, op_code_d, dec_op, r_op;
  logic [SHAMT_W-1:0] shamt;
  logic            accept;
  logic            unused_funct7;
  assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};
  assign shamt         = bus.op_b[SHAMT_W-1:0];
  assign bus.in_ready  = state_q == IDLE | (state_q == DONE & bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = state_q == DONE;
  assign bus.busy      = state_q != IDLE;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.op_code   = op_code_q;
  // I-type (alu_op 11) never subtracts: funct7[5] there is immediate bits, not an opcode modifier
  always_comb begin
    r_op = OP_ADD;
    case (bus.funct3)
      3'b000: r_op = bus.alu_op == 2'b10 && bus.funct7[5] ? OP_SUB : OP_ADD;
      3'b001: r_op = OP_SLL;
      3'b010: r_op = OP_SLT;
      3'b011: r_op = OP_SLTU;
      3'b100: r_op = OP_XOR;
      3'b101: r_op = bus.funct7[5] ? OP_SRA : OP_SRL;
      3'b110: r_op = OP_OR;
      3'b111: r_op = OP_AND;
    endcase
    dec_op = bus.alu_op == 2'b00 ? OP_ADD : bus.alu_op == 2'b01 ? OP_SUB : r_op;
  end
  always_comb begin
    alu_res = bus.op_a;
    case (dec_op)
      OP_ADD:  alu_res = bus.op_a + bus.op_b;
      OP_SUB:  alu_res = bus.op_a - bus.op_b;
      OP_AND:  alu_res = bus.op_a & bus.op_b;
      OP_OR:   alu_res = bus.op_a | bus.op_b;
      OP_XOR:  alu_res = bus.op_a ^ bus.op_b;
      OP_SLT:  alu_res = XLEN'($signed(bus.op_a) < $signed(bus.op_b));
      OP_SLTU: alu_res = XLEN'(bus.op_a < bus.op_b);
`ifdef FAST_SHIFT_EN
      OP_SLL:  alu_res = bus.op_a << shamt;
      OP_SRL:  alu_res = bus.op_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.op_a) >>> shamt);
`endif
      default: ;
    endcase
  end
`ifndef FAST_SHIFT_EN
  logic [XLEN-1:0]    acc_q, acc_d, step;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               is_shift;
  assign is_shift = dec_op == OP_SLL | dec_op == OP_SRL | dec_op == OP_SRA;
  // op_code_q already holds the in-flight shift kind while iterating
  assign step = op_code_q == OP_SLL ? acc_q << 1 : {op_code_q == OP_SRA & acc_q[XLEN-1], acc_q[XLEN-1:1]};
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
`endif
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    op_code_d = op_code_q;
`ifndef FAST_SHIFT_EN
    acc_d = acc_q;
    cnt_d = cnt_q;
`endif
    if (accept) begin
      op_code_d = dec_op;
      result_d  = alu_res;
      zero_d    = alu_res == '0;
      state_d   = DONE;
`ifndef FAST_SHIFT_EN
      if (is_shift && shamt != '0) begin
        result_d = result_q;
        zero_d   = zero_q;
        acc_d    = bus.op_a;
        cnt_d    = shamt;
        state_d  = SHIFT;
      end
`endif
    end else if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
    end
`ifndef FAST_SHIFT_EN
    else if (state_q == SHIFT) begin
      acc_d = step;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == SHAMT_W'(1)) begin
        result_d = step;
        zero_d   = step == '0;
        state_d  = DONE;
      end
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b1;
      op_code_q <= OP_ADD;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      op_code_q <= op_code_d;
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench; the driver pushes model results on accept, a monitor
// compares every cycle the DUT presents out_valid.
module tb_alu_exec_unit;
  localparam int XLEN = 32;
  typedef struct {
    logic [31:0] res;
    logic [3:0]  op;
    int          due;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  int   n_cmp = 0, n_bad = 0, cyc = 0, bp = 0;
  bit   seen = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  alu_exec_if #(.XLEN(XLEN)) bus ();
  alu_exec_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: op code from the decode table, result from plain arithmetic on the operands
  function automatic logic [35:0] model(logic [1:0] ao, logic [2:0] f3, logic f7b, logic [31:0] a, logic [31:0] b);
    logic [3:0]  op;
    logic [31:0] r;
    int          sh;
    sh = int'(b[4:0]);
    if (ao == 2'b00) op = 4'd0;
    else if (ao == 2'b01) op = 4'd1;
    else begin
      case (f3)
        3'd0: op = (ao == 2'b10 && f7b) ? 4'd1 : 4'd0;
        3'd1: op = 4'd5;
        3'd2: op = 4'd8;
        3'd3: op = 4'd9;
        3'd4: op = 4'd4;
        3'd5: op = f7b ? 4'd7 : 4'd6;
        3'd6: op = 4'd3;
        default: op = 4'd2;
      endcase
    end
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << sh;
      4'd6: r = a >> sh;
      4'd7: r = 32'($signed(a) >>> sh);
      4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = (a < b) ? 32'd1 : 32'd0;
    endcase
    return {op, r};
  endfunction

  task automatic drive_ready();
    bus.out_ready = bp == 0 ? ($urandom_range(0, 3) != 0) : (bp == 2);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 0;
      drive_ready();
      #1;
      check("busy", 32'(bus.busy), 32'(sb.size() != 0));
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) idle(1);
  endtask

  task automatic issue(logic [1:0] ao, logic [2:0] f3, logic [6:0] f7, logic [31:0] a, logic [31:0] b);
    logic [35:0] m;
    int          extra;
    m = model(ao, f3, f7[5], a, b);
`ifdef FAST_SHIFT_EN
    extra = 0;
`else
    extra = (m[35:32] inside {4'd5, 4'd6, 4'd7}) ? int'(b[4:0]) : 0;
`endif
    for (int t = 0; t <= 200; t++) begin
      @(negedge clk);
      bus.in_valid = 1;
      bus.alu_op   = ao;
      bus.funct3   = f3;
      bus.funct7   = f7;
      bus.op_a     = a;
      bus.op_b     = b;
      drive_ready();
      #1;
      check("busy", 32'(bus.busy), 32'(sb.size() != 0));
      if (bus.in_ready) begin
        sb.push_back('{res: m[31:0], op: m[35:32], due: cyc + 1 + extra});
        break;
      end
      if (t == 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: in_ready got 0, expected 1 within 200 cycles");
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1;
    bus.in_valid = 1;
    @(posedge clk);
    #1;
    rst          = 0;
    bus.in_valid = 0;
    sb.delete();
    seen = 0;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_result", bus.result, 0);
    check("rst_zero", 32'(bus.zero), 1);
    check("rst_op_code", 32'(bus.op_code), 0);
    check("rst_busy", 32'(bus.busy), 0);
  endtask

  function automatic logic [31:0] pick();
    int k;
    k = $urandom_range(0, 5);
    return k == 0 ? 32'h0 : k == 1 ? 32'hFFFF_FFFF : k == 2 ? 32'h8000_0000 :
           k == 3 ? 32'($urandom_range(0, 40)) : 32'($urandom);
  endfunction

  // Monitor: compares the head of the scoreboard every cycle out_valid is high, pops on handshake
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got out_valid=1 result=%h, expected no pending result", bus.result);
        end else begin
          if (!seen) begin
            check("latency_cycle", 32'(cyc), 32'(sb[0].due));
            seen = 1;
          end
          check("result", bus.result, sb[0].res);
          check("zero", 32'(bus.zero), 32'(sb[0].res == 0));
          check("op_code", 32'(bus.op_code), 32'(sb[0].op));
          if (bus.out_ready) begin
            void'(sb.pop_front());
            seen = 0;
          end
        end
      end else if (sb.size() != 0 && cyc > sb[0].due + 2) begin
        n_cmp++;
        n_bad++;
        $display("FAIL result_timeout: got out_valid=0 at cycle %0d, expected by cycle %0d", cyc, sb[0].due);
        void'(sb.pop_front());
        seen = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected completion before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    bus.in_valid  = 0;
    bus.out_ready = 0;
    bus.alu_op    = 0;
    bus.funct3    = 0;
    bus.funct7    = 0;
    bus.op_a      = 0;
    bus.op_b      = 0;
    do_reset();
    bp = 0;
    issue(2'b10, 3'b000, 7'h20, 32'd10, 32'd3);
    issue(2'b11, 3'b101, 7'h20, 32'h8000_0000, 32'd4);
    issue(2'b10, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1);
    issue(2'b10, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1);
    issue(2'b00, 3'b000, 7'h00, 32'hFFFF_FFFF, 32'd1);
    issue(2'b10, 3'b001, 7'h00, 32'h1234, 32'd0);
    issue(2'b11, 3'b000, 7'h20, 32'd5, 32'd3);
    issue(2'b10, 3'b101, 7'h00, 32'h8000_0000, 32'd31);
    bp = 2;
    drain();
    bp = 1;
    issue(2'b00, 3'b000, 7'h00, 32'd2, 32'd3);
    repeat (5) begin
      idle(1);
      check("hold_in_ready", 32'(bus.in_ready), 0);
    end
    bp = 2;
    issue(2'b10, 3'b100, 7'h00, 32'hF0, 32'hFF);
    drain();
    issue(2'b10, 3'b001, 7'h00, 32'd1, 32'd20);
    idle(5);
    do_reset();
    issue(2'b00, 3'b000, 7'h00, 32'd1, 32'd1);
    bp = 0;
    repeat (300) begin
      a = pick();
      b = pick();
      issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), a, b);
      idle($urandom_range(0, 2));
    end
    bp = 2;
    drain();
    check("drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
